regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports (B has priority), NRD combinational
// read ports with optional write-through forwarding, and a per-register busy scoreboard.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_a,
  input  logic [AW-1:0]        wa_a,
  input  logic [WIDTH-1:0]     wd_a,
  input  logic                 we_b,
  input  logic [AW-1:0]        wa_b,
  input  logic [WIDTH-1:0]     wd_b,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rbusy,
  input  logic                 set_en,
  input  logic [AW-1:0]        set_addr,
  output logic                 wr_err
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             wr_err_q, wr_err_d;

  // Per-register decoded hits; register 0 never matches when hard-wired to zero,
  // and out-of-range addresses match nothing, so both are ignored everywhere below.
  logic [DEPTH-1:0] hit_a, hit_b, hit_set;

  always_comb begin
    hit_a   = '0;
    hit_b   = '0;
    hit_set = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (!(ZERO_REG != 0 && j == 0)) begin
        hit_a[j]   = we_a   && (wa_a     == AW'(j));
        hit_b[j]   = we_b   && (wa_b     == AW'(j));
        hit_set[j] = set_en && (set_addr == AW'(j));
      end
    end
  end

  always_comb begin
    regs_d   = regs_q;
    busy_d   = busy_q;
    wr_err_d = |(hit_a & hit_b);
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (hit_a[j]) regs_d[j] = wd_a;
      if (hit_b[j]) regs_d[j] = wd_b;
      // A new allocation supersedes the retiring write to the same register.
      if (hit_a[j] || hit_b[j]) busy_d[j] = 1'b0;
      if (hit_set[j])           busy_d[j] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < DEPTH; j++) regs_q[j] <= '0;
      busy_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  logic [AW-1:0]    ra_i;
  logic [WIDTH-1:0] val;
  logic             bsy;

  always_comb begin
    rd    = '0;
    rbusy = '0;
    ra_i  = '0;
    val   = '0;
    bsy   = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra_i = ra[i*AW +: AW];
      val  = '0;
      bsy  = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if ((ra_i == AW'(j)) && !(ZERO_REG != 0 && j == 0)) begin
          val = regs_q[j];
          bsy = busy_q[j];
          if (BYPASS != 0) begin
            if (hit_b[j])      val = wd_b;
            else if (hit_a[j]) val = wd_a;
            if ((hit_a[j] || hit_b[j]) && !hit_set[j]) bsy = 1'b0;
          end
        end
      end
      // Forwarded write data must not leak out while reset holds the array clear.
      if (!rst_n) begin
        val = '0;
        bsy = 1'b0;
      end
      rd[i*WIDTH +: WIDTH] = val;
      rbusy[i]             = bsy;
    end
  end

  assign wr_err = wr_err_q;

endmodule
